usb_tx_param: RTL and testbench
===============================

Name: usb_tx_param

Overview:
- Parametrised next-generation USB full-speed packet transmitter for the bulk-endpoint SoC. It replaces the fixed-timing usb_tx.
- Takes a packet request (type and size) from the endpoint buffer/AHB side and pulls payload bytes one at a time.
- Drives the D+/D- pair with SYNC, PID, payload and CRC16, applying bit stuffing and NRZI, followed by EOP.
- Bit timing and maximum payload are parameters; malformed requests raise an error instead of being transmitted.

Parameters:
- CLKS_PER_BIT, 8, clock cycles per USB bit time (at least 4).
- MAX_PKT_BYTES, 64, largest legal DATA payload in bytes.
- SIZE_W, 7, width of tx_packet_size; 2**SIZE_W must be greater than MAX_PKT_BYTES.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  reset; asynchronous, active-low.
- tx_packet  in  3  request code: 0 none, 1 DATA0, 2 ACK, 3 NAK, 4 STALL, 5 DATA1, 6-7 illegal.
- tx_packet_size  in  SIZE_W  payload byte count; sampled with the request and ignored for handshakes.
- tx_packet_data  in  8  payload byte from the buffer.
- get_tx_packet_data  out  1  one-cycle pulse requesting the next payload byte.
- dplus_out  out  1  USB D+ line.
- dminus_out  out  1  USB D- line.
- tx_transfer_active  out  1  high while a packet is on the wire.
- tx_error  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset values: dplus_out=1, dminus_out=0 (J/idle); tx_transfer_active=0; get_tx_packet_data=0; tx_error=0. The NRZI level register resets to J.
- Reset asserted mid-packet aborts the packet immediately. Lines return to J asynchronously and no EOP is sent.
- Request acceptance: in IDLE, a nonzero tx_packet is sampled on a rising edge.
  - Codes 6-7, or DATA with size > MAX_PKT_BYTES: tx_error pulses the next cycle and the block stays IDLE with lines at J.
  - Otherwise the block latches type and size, and tx_transfer_active rises the next cycle with the first SYNC bit.
  - tx_packet is ignored while not IDLE.
- Bit clock: a counter 0..CLKS_PER_BIT-1 advances one bit each time it wraps. Every line value is held for exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP_SE0, EOP_J.
  - SYNC sends byte 0x80, LSB first (7 zeros then 1).
  - PID sends {~pid[3:0], pid[3:0]}, LSB first. Resulting bytes: DATA0 0xC3, DATA1 0x4B, ACK 0xD2, NAK 0x5A, STALL 0x1E.
  - Handshakes go PID to EOP_SE0.
  - DATA packets go PID to DATA (size bytes) to CRC_LO to CRC_HI to EOP_SE0. With size 0, PID goes directly to CRC_LO.
  - EOP_SE0 holds dplus_out=0, dminus_out=0 for 2 bit times.
  - EOP_J holds J for 1 bit time, then the block enters IDLE and tx_transfer_active falls.
- Payload fetch: get_tx_packet_data pulses one cycle at the start of the last bit time of the preceding byte (PID or previous data byte). tx_packet_data is sampled CLKS_PER_BIT-1 cycles later, at the byte boundary. Exactly `size` pulses are issued per packet.
- CRC16: computed over payload bits only.
  - Polynomial x16+x15+x2+1, initial value 0xFFFF, serial LSB-first update.
  - Transmitted value is the complemented remainder: low byte first, each byte LSB first.
  - Empty payload transmits 0x0000.
- Bit stuffing: applies to PID, DATA and CRC bits, not SYNC.
  - After six consecutive 1s, one 0 bit time is inserted.
  - The ones counter clears on any 0, including the stuffed bit.
  - A stuff due after the final CRC bit is still sent before EOP.
  - During a stuffed bit the shift register, CRC and bit counters hold.
- NRZI: a 0 toggles the line state (J to K, K to J) and a 1 holds it. K is dplus=0, dminus=1.
  - SYNC starts from J, so the first transmitted bit is K.
  - EOP bypasses NRZI. The level register resets to J after EOP.

Test Plan:
- Reset with lines idle, then assert n_rst low mid-PID of an ACK: dplus_out=1, dminus_out=0 within the same cycle; tx_transfer_active=0.
- ACK request (CLKS_PER_BIT=8):
  - Decoded bit stream is SYNC 0x80 then 0xD2.
  - tx_transfer_active high for exactly 19 bit times (152 cycles).
  - SE0 for 16 cycles, then J; no get_tx_packet_data pulses.
- DATA0 with size 0: PID 0xC3, CRC bytes 0x00 0x00, active for 35 bit times, zero fetch pulses.
- DATA1 with size 1 and byte 0xFF:
  - Exactly 1 fetch pulse, at the start of the last PID bit time.
  - A stuffed 0 appears after the 6th payload bit.
  - CRC decoded as ~crc16(0xFF), low byte first.
- DATA0 with size 3 and bytes 0x01,0x02,0x03: 3 fetch pulses, spaced 8 bit times apart; decoded payload matches; CRC equals the reference model.
- Illegal requests: tx_packet=6, or DATA0 with size 65: tx_error pulses 1 cycle, tx_transfer_active stays 0, lines stay J. A request issued while busy is ignored.

Source files
------------

// File: rtl/usb_tx_param.sv
// usb_tx_param: USB full-speed packet transmitter (SYNC, PID, payload, CRC16, bit stuffing, NRZI, EOP)
module usb_tx_param #(
    parameter int unsigned CLKS_PER_BIT  = 8,
    parameter int unsigned MAX_PKT_BYTES = 64,
    parameter int unsigned SIZE_W        = 7
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [2:0]        tx_packet,
    input  logic [SIZE_W-1:0] tx_packet_size,
    input  logic [7:0]        tx_packet_data,
    output logic              get_tx_packet_data,
    output logic              dplus_out,
    output logic              dminus_out,
    output logic              tx_transfer_active,
    output logic              tx_error
);

    localparam int unsigned      CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_PID,
        S_DATA,
        S_CRC_LO,
        S_CRC_HI,
        S_EOP_SE0,
        S_EOP_J
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [SIZE_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [7:0]        pid_q, pid_d;
    logic              is_data_q, is_data_d;
    logic [2:0]        ones_q, ones_d;
    logic [15:0]       crc_q, crc_d;
    logic              level_q, level_d;
    logic              dp_q, dp_d;
    logic              dm_q, dm_d;
    logic              active_q, active_d;
    logic              get_q, get_d;
    logic              err_q, err_d;

    logic [3:0]        req_nib_c;
    logic              req_data_c;
    logic              req_legal_c;

    logic              boundary_c;
    logic              byte_state_c;
    logic              launch_c;
    logic              tx_bit_c;
    logic              stuffable_c;
    logic              crc_en_c;
    logic              load_c;
    logic [7:0]        load_byte_c;
    logic              eop_c;
    logic              fb_c;

    // Decode the request code into a PID nibble and check it is transmittable
    always_comb begin
        req_nib_c   = 4'h0;
        req_data_c  = 1'b0;
        req_legal_c = 1'b1;
        case (tx_packet)
            3'd1: begin
                req_nib_c  = 4'b0011;
                req_data_c = 1'b1;
            end
            3'd2: req_nib_c = 4'b0010;
            3'd3: req_nib_c = 4'b1010;
            3'd4: req_nib_c = 4'b1110;
            3'd5: begin
                req_nib_c  = 4'b1011;
                req_data_c = 1'b1;
            end
            default: req_legal_c = 1'b0;
        endcase
        if (req_data_c && (tx_packet_size > SIZE_W'(MAX_PKT_BYTES))) begin
            req_legal_c = 1'b0;
        end
    end

    // Sequencing: at each bit boundary pick the next bit (stuffed 0, next bit, or next field), then NRZI-encode it
    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_cnt_d  = byte_cnt_q;
        size_d      = size_q;
        pid_d       = pid_q;
        is_data_d   = is_data_q;
        ones_d      = ones_q;
        crc_d       = crc_q;
        level_d     = level_q;
        dp_d        = dp_q;
        dm_d        = dm_q;
        active_d    = active_q;
        get_d       = 1'b0;
        err_d       = 1'b0;
        launch_c    = 1'b0;
        tx_bit_c    = 1'b0;
        stuffable_c = 1'b0;
        crc_en_c    = 1'b0;
        load_c      = 1'b0;
        load_byte_c = 8'h00;
        eop_c       = 1'b0;
        fb_c        = 1'b0;
        boundary_c  = (clk_cnt_q == CNT_LAST);
        byte_state_c = (state_q == S_SYNC) || (state_q == S_PID) || (state_q == S_DATA) ||
                       (state_q == S_CRC_LO) || (state_q == S_CRC_HI);

        if (state_q == S_IDLE) begin
            clk_cnt_d = '0;
            if (tx_packet != 3'd0) begin
                if (!req_legal_c) begin
                    err_d = 1'b1;
                end else begin
                    state_d     = S_SYNC;
                    pid_d       = {~req_nib_c, req_nib_c};
                    is_data_d   = req_data_c;
                    size_d      = tx_packet_size;
                    crc_d       = 16'hFFFF;
                    active_d    = 1'b1;
                    load_c      = 1'b1;
                    load_byte_c = 8'h80;
                end
            end
        end else begin
            clk_cnt_d = boundary_c ? '0 : clk_cnt_q + CNT_W'(1);
            if (boundary_c) begin
                if (ones_q == 3'd6) begin
                    // stuffed zero: shift register, CRC and bit counter hold
                    launch_c = 1'b1;
                    tx_bit_c = 1'b0;
                end else if (byte_state_c && (bit_cnt_q != 3'd7)) begin
                    shift_d     = {shift_q[0], shift_q[7:1]};
                    bit_cnt_d   = bit_cnt_q + 3'd1;
                    launch_c    = 1'b1;
                    tx_bit_c    = shift_q[1];
                    stuffable_c = (state_q != S_SYNC);
                    crc_en_c    = (state_q == S_DATA);
                    // fetch request lines up with the last bit of the byte preceding a payload byte
                    if (bit_cnt_q == 3'd6) begin
                        get_d = ((state_q == S_PID) && is_data_q && (size_q != '0)) ||
                                ((state_q == S_DATA) && (byte_cnt_q > SIZE_W'(1)));
                    end
                end else begin
                    case (state_q)
                        S_SYNC: begin
                            state_d     = S_PID;
                            load_c      = 1'b1;
                            load_byte_c = pid_q;
                        end
                        S_PID: begin
                            if (!is_data_q) begin
                                eop_c = 1'b1;
                            end else if (size_q == '0) begin
                                state_d     = S_CRC_LO;
                                load_c      = 1'b1;
                                load_byte_c = ~crc_q[7:0];
                            end else begin
                                state_d     = S_DATA;
                                byte_cnt_d  = size_q;
                                load_c      = 1'b1;
                                load_byte_c = tx_packet_data;
                                crc_en_c    = 1'b1;
                            end
                        end
                        S_DATA: begin
                            if (byte_cnt_q > SIZE_W'(1)) begin
                                byte_cnt_d  = byte_cnt_q - SIZE_W'(1);
                                load_c      = 1'b1;
                                load_byte_c = tx_packet_data;
                                crc_en_c    = 1'b1;
                            end else begin
                                state_d     = S_CRC_LO;
                                load_c      = 1'b1;
                                load_byte_c = ~crc_q[7:0];
                            end
                        end
                        S_CRC_LO: begin
                            state_d     = S_CRC_HI;
                            load_c      = 1'b1;
                            load_byte_c = ~crc_q[15:8];
                        end
                        S_CRC_HI: eop_c = 1'b1;
                        S_EOP_SE0: begin
                            if (bit_cnt_q == 3'd0) begin
                                bit_cnt_d = 3'd1;
                            end else begin
                                state_d   = S_EOP_J;
                                bit_cnt_d = 3'd0;
                                dp_d      = 1'b1;
                                dm_d      = 1'b0;
                                level_d   = 1'b1;
                            end
                        end
                        S_EOP_J: begin
                            state_d  = S_IDLE;
                            active_d = 1'b0;
                            dp_d     = 1'b1;
                            dm_d     = 1'b0;
                            level_d  = 1'b1;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        end

        if (eop_c) begin
            state_d   = S_EOP_SE0;
            bit_cnt_d = 3'd0;
            ones_d    = 3'd0;
            dp_d      = 1'b0;
            dm_d      = 1'b0;
        end

        if (load_c) begin
            shift_d     = load_byte_c;
            bit_cnt_d   = 3'd0;
            launch_c    = 1'b1;
            tx_bit_c    = load_byte_c[0];
            stuffable_c = (state_d != S_SYNC);
        end

        if (launch_c) begin
            level_d = tx_bit_c ? level_q : ~level_q;
            dp_d    = level_d;
            dm_d    = ~level_d;
            ones_d  = (stuffable_c && tx_bit_c) ? ones_q + 3'd1 : 3'd0;
            if (crc_en_c) begin
                fb_c  = tx_bit_c ^ crc_q[0];
                crc_d = {1'b0, crc_q[15:1]} ^ (fb_c ? 16'hA001 : 16'h0000);
            end
        end
    end

    // State and output registers; reset puts the lines at J immediately
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            byte_cnt_q <= '0;
            size_q     <= '0;
            pid_q      <= 8'h00;
            is_data_q  <= 1'b0;
            ones_q     <= 3'd0;
            crc_q      <= 16'hFFFF;
            level_q    <= 1'b1;
            dp_q       <= 1'b1;
            dm_q       <= 1'b0;
            active_q   <= 1'b0;
            get_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            size_q     <= size_d;
            pid_q      <= pid_d;
            is_data_q  <= is_data_d;
            ones_q     <= ones_d;
            crc_q      <= crc_d;
            level_q    <= level_d;
            dp_q       <= dp_d;
            dm_q       <= dm_d;
            active_q   <= active_d;
            get_q      <= get_d;
            err_q      <= err_d;
        end
    end

    assign get_tx_packet_data = get_q;
    assign dplus_out          = dp_q;
    assign dminus_out         = dm_q;
    assign tx_transfer_active = active_q;
    assign tx_error           = err_q;

endmodule

// File: tb/tb_usb_tx_param.sv
// tb_usb_tx_param: line-level checks of usb_tx_param against a byte/bit-stream packet model
module tb_usb_tx_param;

    localparam int unsigned CPB  = 8;
    localparam int unsigned MAXB = 64;
    localparam int unsigned SW   = 7;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic [2:0]    tx_packet = 3'd0;
    logic [SW-1:0] tx_packet_size = '0;
    logic [7:0]    tx_packet_data = 8'h00;
    logic          get_tx_packet_data;
    logic          dplus_out;
    logic          dminus_out;
    logic          tx_transfer_active;
    logic          tx_error;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] pay[$];
    logic [1:0] obs_g[$];
    int         pulses_g[$];

    usb_tx_param #(
        .CLKS_PER_BIT (CPB),
        .MAX_PKT_BYTES(MAXB),
        .SIZE_W       (SW)
    ) dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .tx_packet         (tx_packet),
        .tx_packet_size    (tx_packet_size),
        .tx_packet_data    (tx_packet_data),
        .get_tx_packet_data(get_tx_packet_data),
        .dplus_out         (dplus_out),
        .dminus_out        (dminus_out),
        .tx_transfer_active(tx_transfer_active),
        .tx_error          (tx_error)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pid_of(input logic [2:0] code);
        case (code)
            3'd1:    return 8'hC3;
            3'd2:    return 8'hD2;
            3'd3:    return 8'h5A;
            3'd4:    return 8'h1E;
            3'd5:    return 8'h4B;
            default: return 8'h00;
        endcase
    endfunction

    // CRC16 of the payload in textbook MSB-first form (poly 0x8005), converted to the on-wire LSB-first value
    function automatic logic [15:0] crc_model();
        logic [15:0] r;
        logic [15:0] rev;
        logic        fb;
        r = 16'hFFFF;
        foreach (pay[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = r[15] ^ pay[i][b];
                r  = {r[14:0], 1'b0};
                if (fb) r = r ^ 16'h8005;
            end
        end
        for (int k = 0; k < 16; k++) rev[k] = r[15-k];
        return ~rev;
    endfunction

    // Send one request, record the wire for as long as tx_transfer_active is high, compare with the model
    task automatic run_pkt(input logic [2:0] code, input int size, input string name, input bit inject);
        logic [7:0] bytes_q[$];
        logic [1:0] exp_sym[$];
        int         last_t[$];
        int         exp_pulse[$];
        logic [1:0] obs[$];
        int         obs_pulse[$];
        logic [7:0] dec[$];
        logic [15:0] crc;
        logic       lvl;
        logic       bitv;
        int         ones;
        int         pidx;
        int         budget;
        int         nbad;
        int         first_bad;
        bit         ok;
        bit         is_data;
        logic [1:0] prev;
        logic [1:0] s;
        logic [7:0] cur;
        int         nb;

        is_data = (code == 3'd1) || (code == 3'd5);
        bytes_q.push_back(8'h80);
        bytes_q.push_back(pid_of(code));
        if (is_data) begin
            crc = crc_model();
            foreach (pay[i]) bytes_q.push_back(pay[i]);
            bytes_q.push_back(crc[7:0]);
            bytes_q.push_back(crc[15:8]);
        end

        lvl  = 1'b1;
        ones = 0;
        foreach (bytes_q[i]) begin
            for (int b = 0; b < 8; b++) begin
                bitv = bytes_q[i][b];
                if (b == 7) last_t.push_back(exp_sym.size());
                if (!bitv) lvl = ~lvl;
                exp_sym.push_back(lvl ? 2'b10 : 2'b01);
                if (i >= 1) begin
                    ones = bitv ? ones + 1 : 0;
                    if (ones == 6) begin
                        lvl = ~lvl;
                        exp_sym.push_back(lvl ? 2'b10 : 2'b01);
                        ones = 0;
                    end
                end
            end
        end
        exp_sym.push_back(2'b00);
        exp_sym.push_back(2'b00);
        exp_sym.push_back(2'b10);
        if (is_data) begin
            for (int i = 1; i <= size; i++) exp_pulse.push_back(last_t[i] * CPB);
        end

        @(negedge clk);
        tx_packet      = code;
        tx_packet_size = SW'(size);
        @(negedge clk);
        tx_packet = 3'd0;
        pidx   = 0;
        budget = exp_sym.size() * CPB + 40;
        for (int c = 0; c < budget; c++) begin
            if (inject && c == 40) begin
                tx_packet      = 3'd1;
                tx_packet_size = SW'(3);
            end
            if (inject && c == 48) tx_packet = 3'd0;
            if (!tx_transfer_active) break;
            obs.push_back({dplus_out, dminus_out});
            if (get_tx_packet_data) begin
                obs_pulse.push_back(c);
                tx_packet_data = (pidx < pay.size()) ? pay[pidx] : 8'h00;
                pidx++;
            end
            @(negedge clk);
        end
        obs_g    = obs;
        pulses_g = obs_pulse;

        n_total++;
        if (obs.size() !== exp_sym.size() * CPB) begin
            $display("FAIL %s active_len: got %0d cycles, expected %0d", name, obs.size(), exp_sym.size() * CPB);
        end else n_pass++;

        nbad      = 0;
        first_bad = -1;
        for (int c = 0; c < obs.size() && c < exp_sym.size() * CPB; c++) begin
            if (obs[c] !== exp_sym[c / CPB]) begin
                if (first_bad < 0) first_bad = c;
                nbad++;
            end
        end
        n_total++;
        if (nbad !== 0) begin
            $display("FAIL %s waveform: %0d bad cycles, first at cycle %0d got %b expected %b",
                     name, nbad, first_bad, obs[first_bad], exp_sym[first_bad / CPB]);
        end else n_pass++;

        ok = (obs_pulse.size() == exp_pulse.size());
        for (int i = 0; ok && i < exp_pulse.size(); i++) if (obs_pulse[i] != exp_pulse[i]) ok = 1'b0;
        n_total++;
        if (!ok) begin
            $display("FAIL %s fetch_pulses: got %0d pulses (first at %0d), expected %0d (first at %0d)", name,
                     obs_pulse.size(), (obs_pulse.size() > 0) ? obs_pulse[0] : -1,
                     exp_pulse.size(), (exp_pulse.size() > 0) ? exp_pulse[0] : -1);
        end else n_pass++;

        prev = 2'b10;
        ones = 0;
        nb   = 0;
        cur  = 8'h00;
        for (int b = 0; b * CPB + CPB / 2 < obs.size(); b++) begin
            s = obs[b * CPB + CPB / 2];
            if (s == 2'b00) break;
            bitv = (s == prev);
            prev = s;
            if (dec.size() >= 1 && ones == 6) begin
                ones = 0;
            end else begin
                if (dec.size() >= 1) ones = bitv ? ones + 1 : 0;
                cur[nb] = bitv;
                nb++;
                if (nb == 8) begin
                    dec.push_back(cur);
                    nb = 0;
                end
            end
        end
        ok = (dec.size() == bytes_q.size());
        for (int i = 0; ok && i < bytes_q.size(); i++) if (dec[i] !== bytes_q[i]) ok = 1'b0;
        n_total++;
        if (!ok) begin
            $display("FAIL %s decoded: got %0d bytes (byte1 %h), expected %0d bytes (byte1 %h)", name,
                     dec.size(), (dec.size() > 1) ? dec[1] : 8'hxx, bytes_q.size(), bytes_q[1]);
        end else n_pass++;
    endtask

    task automatic test_reset();
        n_total++;
        if ({dplus_out, dminus_out, tx_transfer_active, get_tx_packet_data, tx_error} !== 5'b10000) begin
            $display("FAIL reset_values: got dp/dm/act/get/err=%b expected 10000",
                     {dplus_out, dminus_out, tx_transfer_active, get_tx_packet_data, tx_error});
        end else n_pass++;

        @(negedge clk);
        tx_packet = 3'd2;
        @(negedge clk);
        tx_packet = 3'd0;
        repeat (10 * CPB + 3) @(negedge clk);
        n_total++;
        if ({tx_transfer_active, dplus_out, dminus_out} !== 3'b101) begin
            $display("FAIL reset_pre_abort: got act/dp/dm=%b expected 101 (K in PID bit 2)",
                     {tx_transfer_active, dplus_out, dminus_out});
        end else n_pass++;

        #1 n_rst = 1'b0;
        #1;
        n_total++;
        if ({dplus_out, dminus_out, tx_transfer_active} !== 3'b100) begin
            $display("FAIL reset_abort: got dp/dm/act=%b expected 100", {dplus_out, dminus_out, tx_transfer_active});
        end else n_pass++;

        @(negedge clk);
        n_rst = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        n_total++;
        if ({dplus_out, dminus_out, tx_transfer_active} !== 3'b100) begin
            $display("FAIL reset_no_eop: got dp/dm/act=%b expected 100", {dplus_out, dminus_out, tx_transfer_active});
        end else n_pass++;
    endtask

    task automatic test_ack();
        pay.delete();
        run_pkt(3'd2, 0, "ack", 1'b0);
        n_total++;
        if (obs_g.size() !== 19 * CPB) begin
            $display("FAIL ack_19_bits: got %0d cycles expected %0d", obs_g.size(), 19 * CPB);
        end else n_pass++;
    endtask

    task automatic test_data0_empty();
        pay.delete();
        run_pkt(3'd1, 0, "data0_empty", 1'b0);
        n_total++;
        if (obs_g.size() !== 35 * CPB) begin
            $display("FAIL data0_empty_35_bits: got %0d cycles expected %0d", obs_g.size(), 35 * CPB);
        end else n_pass++;
    endtask

    task automatic test_data1_ff();
        logic [1:0] s21;
        logic [1:0] s22;
        int         p0;
        pay.delete();
        pay.push_back(8'hFF);
        run_pkt(3'd5, 1, "data1_ff", 1'b0);
        p0 = (pulses_g.size() == 1) ? pulses_g[0] : -1;
        n_total++;
        if (p0 !== 15 * CPB) begin
            $display("FAIL data1_ff_pulse: got %0d pulses, first at %0d, expected 1 at %0d", pulses_g.size(), p0, 15 * CPB);
        end else n_pass++;
        s21 = (obs_g.size() > 23 * CPB) ? obs_g[21 * CPB + CPB / 2] : 2'bxx;
        s22 = (obs_g.size() > 23 * CPB) ? obs_g[22 * CPB + CPB / 2] : 2'bxx;
        n_total++;
        if ({s21, s22} !== 4'b0110) begin
            $display("FAIL data1_ff_stuff: got bit21/bit22 %b/%b expected 01/10", s21, s22);
        end else n_pass++;
    endtask

    task automatic test_data0_three();
        int d1;
        int d2;
        pay.delete();
        pay.push_back(8'h01);
        pay.push_back(8'h02);
        pay.push_back(8'h03);
        run_pkt(3'd1, 3, "data0_three", 1'b0);
        d1 = (pulses_g.size() == 3) ? pulses_g[1] - pulses_g[0] : -1;
        d2 = (pulses_g.size() == 3) ? pulses_g[2] - pulses_g[1] : -1;
        n_total++;
        if (d1 !== 8 * CPB || d2 !== 8 * CPB) begin
            $display("FAIL data0_three_spacing: got %0d pulses spacing %0d/%0d expected 3 spacing %0d",
                     pulses_g.size(), d1, d2, 8 * CPB);
        end else n_pass++;
    endtask

    task automatic test_illegal(input logic [2:0] code, input int size, input string name);
        int err_cnt = 0;
        int act_cnt = 0;
        int line_bad = 0;
        @(negedge clk);
        tx_packet      = code;
        tx_packet_size = SW'(size);
        @(negedge clk);
        tx_packet = 3'd0;
        for (int c = 0; c < 3 * CPB; c++) begin
            err_cnt  += int'(tx_error);
            act_cnt  += int'(tx_transfer_active);
            if ({dplus_out, dminus_out} !== 2'b10) line_bad++;
            @(negedge clk);
        end
        n_total++;
        if (err_cnt !== 1) begin
            $display("FAIL %s error_pulse: got %0d error cycles expected 1", name, err_cnt);
        end else n_pass++;
        n_total++;
        if (act_cnt !== 0) begin
            $display("FAIL %s stays_idle: got %0d active cycles expected 0", name, act_cnt);
        end else n_pass++;
        n_total++;
        if (line_bad !== 0) begin
            $display("FAIL %s lines_j: got %0d non-J cycles expected 0", name, line_bad);
        end else n_pass++;
    endtask

    task automatic test_busy();
        int act_cnt = 0;
        int get_cnt = 0;
        pay.delete();
        run_pkt(3'd2, 0, "busy_ack", 1'b1);
        for (int c = 0; c < 30; c++) begin
            act_cnt += int'(tx_transfer_active);
            get_cnt += int'(get_tx_packet_data);
            @(negedge clk);
        end
        n_total++;
        if (act_cnt !== 0 || get_cnt !== 0) begin
            $display("FAIL busy_ignored: got %0d active and %0d fetch cycles after packet, expected 0/0", act_cnt, get_cnt);
        end else n_pass++;
    endtask

    task automatic test_random();
        logic [2:0] code;
        int         size;
        for (int n = 0; n < 8; n++) begin
            code = (n == 0) ? 3'd5 : 3'($urandom_range(1, 5));
            size = 0;
            pay.delete();
            if (code == 3'd1 || code == 3'd5) begin
                size = (n == 0) ? int'(MAXB) : int'($urandom_range(0, 10));
                for (int i = 0; i < size; i++) begin
                    pay.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
                end
            end
            run_pkt(code, size, $sformatf("random%0d", n), 1'b0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_ack();
        test_data0_empty();
        test_data1_ff();
        test_data0_three();
        test_illegal(3'd6, 0, "illegal_code6");
        test_illegal(3'd7, 5, "illegal_code7");
        test_illegal(3'd1, 65, "illegal_size65");
        test_busy();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
